// File: rtl/vscale_mul_div_issue_pkg.sv
// Shared constants for the multiply/divide issue stage: datapath width,
// op encoding width, the op encodings and the issue state encoding.
package vscale_mul_div_issue_pkg;

  localparam int XPR_LEN          = 32;
  localparam int MUL_DIV_OP_WIDTH = 2;

  localparam logic [MUL_DIV_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MUL_DIV_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MUL_DIV_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  // Issue state encoding
  typedef enum logic [1:0] {
    MD_ISSUE_IDLE  = 2'd0,
    MD_ISSUE_WAIT  = 2'd1,
    MD_ISSUE_DONE  = 2'd2,
    MD_ISSUE_DRAIN = 2'd3
  } md_issue_state_e;

  localparam int MD_ISSUE_CNT_WIDTH = 8;

endpackage

// File: rtl/vscale_mul_div_issue.sv
// Issue/writeback sequencer between the pipeline and the multiply/divide
// unit: registers one command, waits for its response, holds the result
// until writeback takes it, and handles flushes, timeouts and stray responses.
module vscale_mul_div_issue
  import vscale_mul_div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [MUL_DIV_OP_WIDTH-1:0] cmd_op,
  input  logic [XPR_LEN-1:0]          cmd_in_1,
  input  logic [XPR_LEN-1:0]          cmd_in_2,
  input  logic                        kill,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [XPR_LEN-1:0]          result_data,
  output logic                        req_valid,
  output logic [MUL_DIV_OP_WIDTH-1:0] req_op,
  output logic [XPR_LEN-1:0]          req_in_1,
  output logic [XPR_LEN-1:0]          req_in_2,
  input  logic                        resp_valid,
  input  logic [XPR_LEN-1:0]          resp_out,
  output logic                        protocol_err
);

  localparam logic [MD_ISSUE_CNT_WIDTH-1:0] CntLast =
    MD_ISSUE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  md_issue_state_e                 state_q, state_d;
  logic [MD_ISSUE_CNT_WIDTH-1:0]   counter_q, counter_d;
  logic                            req_valid_q, req_valid_d;
  logic [MUL_DIV_OP_WIDTH-1:0]     req_op_q, req_op_d;
  logic [XPR_LEN-1:0]              req_in_1_q, req_in_1_d;
  logic [XPR_LEN-1:0]              req_in_2_q, req_in_2_d;
  logic [XPR_LEN-1:0]              result_data_q, result_data_d;
  logic                            err_q, err_d;
  logic                            accept;

  assign cmd_ready    = (state_q == MD_ISSUE_IDLE);
  assign accept       = cmd_ready && cmd_valid && !kill;
  assign result_valid = (state_q == MD_ISSUE_DONE);
  assign req_valid    = req_valid_q;
  assign req_op       = req_op_q;
  assign req_in_1     = req_in_1_q;
  assign req_in_2     = req_in_2_q;
  assign result_data  = result_data_q;
  assign protocol_err = err_q;

  // Next-state, request capture, result capture, timeout and error logic
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    req_valid_d   = accept;
    req_op_d      = req_op_q;
    req_in_1_d    = req_in_1_q;
    req_in_2_d    = req_in_2_q;
    result_data_d = result_data_q;
    err_d         = err_q;

    if (resp_valid && ((state_q == MD_ISSUE_IDLE) || (state_q == MD_ISSUE_DONE) ||
                       req_valid_q)) begin
      err_d = 1'b1;
    end

    case (state_q)
      MD_ISSUE_IDLE: begin
        if (accept) begin
          state_d    = MD_ISSUE_WAIT;
          counter_d  = '0;
          req_op_d   = cmd_op;
          req_in_1_d = cmd_in_1;
          req_in_2_d = cmd_in_2;
        end
      end
      MD_ISSUE_WAIT: begin
        if (kill && resp_valid) begin
          state_d = MD_ISSUE_IDLE;
        end else if (kill) begin
          state_d   = MD_ISSUE_DRAIN;
          counter_d = '0;
        end else if (resp_valid && !req_valid_q) begin
          state_d       = MD_ISSUE_DONE;
          result_data_d = resp_out;
        end else if (counter_q == CntLast) begin
          state_d = MD_ISSUE_IDLE;
          err_d   = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      MD_ISSUE_DRAIN: begin
        if (resp_valid) begin
          state_d = MD_ISSUE_IDLE;
        end else if (counter_q == CntLast) begin
          state_d = MD_ISSUE_IDLE;
          err_d   = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      MD_ISSUE_DONE: begin
        if (kill || result_ready) begin
          state_d = MD_ISSUE_IDLE;
        end
      end
      default: begin
        state_d = MD_ISSUE_IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= MD_ISSUE_IDLE;
      counter_q     <= '0;
      req_valid_q   <= 1'b0;
      req_op_q      <= '0;
      req_in_1_q    <= '0;
      req_in_2_q    <= '0;
      result_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      req_valid_q   <= req_valid_d;
      req_op_q      <= req_op_d;
      req_in_1_q    <= req_in_1_d;
      req_in_2_q    <= req_in_2_d;
      result_data_q <= result_data_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_vscale_mul_div_issue.sv
// Directed bench for the multiply/divide issue stage.
module tb_vscale_mul_div_issue;
  import vscale_mul_div_issue_pkg::*;

  logic                        clk;
  logic                        reset_n;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [MUL_DIV_OP_WIDTH-1:0] cmd_op;
  logic [XPR_LEN-1:0]          cmd_in_1;
  logic [XPR_LEN-1:0]          cmd_in_2;
  logic                        kill;
  logic                        result_valid;
  logic                        result_ready;
  logic [XPR_LEN-1:0]          result_data;
  logic                        req_valid;
  logic [MUL_DIV_OP_WIDTH-1:0] req_op;
  logic [XPR_LEN-1:0]          req_in_1;
  logic [XPR_LEN-1:0]          req_in_2;
  logic                        resp_valid;
  logic [XPR_LEN-1:0]          resp_out;
  logic                        protocol_err;

  int errorCount = 0;
  int checkCount = 0;

  vscale_mul_div_issue #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_in_1(cmd_in_1), .cmd_in_2(cmd_in_2), .kill(kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .req_valid(req_valid), .req_op(req_op), .req_in_1(req_in_1), .req_in_2(req_in_2),
    .resp_valid(resp_valid), .resp_out(resp_out), .protocol_err(protocol_err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic k);
    cmd_valid = v;
    cmd_op    = op;
    cmd_in_1  = a;
    cmd_in_2  = b;
    kill      = k;
  endtask

  initial begin
    reset_n = 1'b0; result_ready = 1'b0; resp_valid = 1'b0; resp_out = '0;
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_req_valid", {31'd0, req_valid}, 32'd0);
    checkOutput("rst_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, protocol_err}, 32'd0);
    checkOutput("rst_result_data", result_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // MUL 7*6, response three cycles after the request
    applyStimulus(1'b1, MD_OP_MUL, 32'd7, 32'd6, 1'b0);
    checkOutput("mul_cmd_ready_T", {31'd0, cmd_ready}, 32'd1);
    tick();                                              // T+1
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("mul_req_valid_T1", {31'd0, req_valid}, 32'd1);
    checkOutput("mul_req_op", {30'd0, req_op}, {30'd0, MD_OP_MUL});
    checkOutput("mul_req_in_1", req_in_1, 32'd7);
    checkOutput("mul_req_in_2", req_in_2, 32'd6);
    checkOutput("mul_cmd_ready_T1", {31'd0, cmd_ready}, 32'd0);
    tick();                                              // T+2
    checkOutput("mul_req_valid_T2", {31'd0, req_valid}, 32'd0);
    tick();                                              // T+3
    tick();                                              // T+4
    resp_valid = 1'b1; resp_out = 32'd42;
    checkOutput("mul_result_valid_T4", {31'd0, result_valid}, 32'd0);
    tick();                                              // T+5
    resp_valid = 1'b0; resp_out = 32'd0;
    checkOutput("mul_result_valid_T5", {31'd0, result_valid}, 32'd1);
    checkOutput("mul_result_data", result_data, 32'd42);
    checkOutput("mul_req_in_1_hold", req_in_1, 32'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_result_valid", {31'd0, result_valid}, 32'd1);
      checkOutput("hold_result_data", result_data, 32'd42);
      checkOutput("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput("mul_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("mul_idle_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("mul_err", {31'd0, protocol_err}, 32'd0);

    // DIV killed in WAIT, late response drained
    applyStimulus(1'b1, MD_OP_DIV, 32'd100, 32'd7, 1'b0);
    tick();                                              // T+1
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("div_req_valid", {31'd0, req_valid}, 32'd1);
    tick();                                              // T+2
    kill = 1'b1;
    tick();                                              // T+3
    kill = 1'b0;
    checkOutput("drain_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick(); tick(); tick();                              // T+6
    resp_valid = 1'b1; resp_out = 32'd14;
    checkOutput("drain_result_valid", {31'd0, result_valid}, 32'd0);
    tick();                                              // T+7
    resp_valid = 1'b0; resp_out = 32'd0;
    checkOutput("drain_idle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("drain_result_valid_T7", {31'd0, result_valid}, 32'd0);
    checkOutput("drain_err", {31'd0, protocol_err}, 32'd0);
    checkOutput("drain_result_data_kept", result_data, 32'd42);

    // kill coincident with response in WAIT
    applyStimulus(1'b1, MD_OP_REM, 32'd9, 32'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    tick();
    resp_valid = 1'b1; resp_out = 32'd1; kill = 1'b1;
    tick();
    resp_valid = 1'b0; resp_out = 32'd0; kill = 1'b0;
    checkOutput("kr_idle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("kr_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("kr_result_data", result_data, 32'd42);

    // command offered with kill in IDLE is not accepted
    applyStimulus(1'b1, MD_OP_MUL, 32'd5, 32'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("killcmd_req_valid", {31'd0, req_valid}, 32'd0);
    checkOutput("killcmd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("killcmd_req_in_1", req_in_1, 32'd9);

    // kill while the result is waiting in DONE
    applyStimulus(1'b1, MD_OP_MUL, 32'd3, 32'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    tick();
    resp_valid = 1'b1; resp_out = 32'd9;
    tick();
    resp_valid = 1'b0; resp_out = 32'd0;
    checkOutput("kd_result_valid", {31'd0, result_valid}, 32'd1);
    checkOutput("kd_result_data", result_data, 32'd9);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("kd_dropped", {31'd0, result_valid}, 32'd0);
    checkOutput("kd_idle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("kd_err", {31'd0, protocol_err}, 32'd0);

    // timeout with no response: IDLE eight cycles after entering WAIT
    applyStimulus(1'b1, MD_OP_MUL, 32'd1, 32'd1, 1'b0);
    tick();                                              // T+1
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();                  // T+8
    checkOutput("to_still_wait", {31'd0, cmd_ready}, 32'd0);
    checkOutput("to_err_before", {31'd0, protocol_err}, 32'd0);
    tick();                                              // T+9
    checkOutput("to_idle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("to_err", {31'd0, protocol_err}, 32'd1);
    checkOutput("to_result_valid", {31'd0, result_valid}, 32'd0);

    // asynchronous reset mid-operation, then a stray response
    applyStimulus(1'b1, MD_OP_DIV, 32'd5, 32'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("ar_req_valid_before", {31'd0, req_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_req_valid", {31'd0, req_valid}, 32'd0);
    checkOutput("ar_req_in_1", req_in_1, 32'd0);
    checkOutput("ar_result_data", result_data, 32'd0);
    checkOutput("ar_err", {31'd0, protocol_err}, 32'd0);
    checkOutput("ar_result_valid", {31'd0, result_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    resp_valid = 1'b1; resp_out = 32'd25;
    tick();
    resp_valid = 1'b0; resp_out = 32'd0;
    checkOutput("stray_err", {31'd0, protocol_err}, 32'd1);
    checkOutput("stray_result_valid", {31'd0, result_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vscale_mul_div_issue.md
VSCALE_MUL_DIV_ISSUE -- requirements
Module: vscale_mul_div_issue

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 63, maximum cycles in WAIT/DRAIN before abandoning an op (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cmd_valid input 1, cmd_ready output 1, cmd_op input MUL_DIV_OP_WIDTH, cmd_in_1 input XPR_LEN, cmd_in_2 input XPR_LEN; pipeline-side command handshake.
REQ-005 SHALL have port: kill  input  1  pipeline flush of the in-flight or offered op.
REQ-006 SHALL have ports: result_valid output 1, result_ready input 1, result_data output XPR_LEN; writeback handshake.
REQ-007 SHALL have ports: req_valid output 1, req_op output MUL_DIV_OP_WIDTH, req_in_1 output XPR_LEN, req_in_2 output XPR_LEN; request side toward vscale_mul_div.
REQ-008 SHALL have ports: resp_valid input 1, resp_out input XPR_LEN; response from vscale_mul_div.
REQ-009 SHALL have port: protocol_err  output  1  sticky error flag.

Function
REQ-010 SHALL implement states IDLE, WAIT, DONE, DRAIN.
REQ-011 cmd_ready SHALL equal (state==IDLE), combinational.
REQ-012 Accept SHALL occur when state==IDLE, cmd_valid=1, kill=0; a command offered with kill=1 is not accepted.
REQ-013 On accept at cycle T: cmd_op/in_1/in_2 SHALL be registered onto req_op/req_in_1/req_in_2, req_valid=1 for exactly cycle T+1, state->WAIT.
REQ-014 req_op/req_in_* SHALL hold stable from T+1 until the next accept.
REQ-015 WAIT, resp_valid=1, kill=0, req_valid=0: resp_out SHALL be captured into result_data, state->DONE; result_valid=1 from next cycle.
REQ-016 DONE: result_valid=1 and result_data stable until result_ready=1; then state->IDLE next cycle (one bubble, no same-cycle re-accept).
REQ-017 Latency: response at T+1+N (N>=1) SHALL give result_valid at T+2+N.
REQ-018 kill in WAIT without resp_valid SHALL move to DRAIN; in DRAIN the next resp_valid SHALL be discarded and state->IDLE.
REQ-019 kill in WAIT coincident with resp_valid SHALL discard the response, state->IDLE.
REQ-020 kill in DONE SHALL drop result_valid next cycle, state->IDLE; kill in DRAIN or IDLE (no accept) SHALL have no effect.
REQ-021 A cycle counter SHALL clear on entry to WAIT/DRAIN and increment each cycle there; reaching TIMEOUT_CYCLES SHALL force state->IDLE, no result, protocol_err=1.
REQ-022 protocol_err SHALL also set on resp_valid while state is IDLE or DONE, or while req_valid=1; it is cleared only by reset.
REQ-023 result_data SHALL be unchanged except on capture (REQ-015).

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=IDLE, req_valid=0, result_valid=0, protocol_err=0, counter=0, req_op/req_in_*/result_data=0, including mid-operation.
REQ-025 A response arriving after reset release for a pre-reset op SHALL set protocol_err (REQ-022).

Structure
REQ-026 XPR_LEN, MUL_DIV_OP_WIDTH and op encodings SHALL come from shared headers vscale_ctrl_constants.vh / vscale_alu_ops.vh; state encoding SHALL be defined in vscale_ctrl_constants.vh as MD_ISSUE_* macros.
REQ-027 The block SHALL be flat, no sub-module; target 120-400 RTL lines.

Verification
REQ-028 MUL, in_1=7, in_2=6 accepted at T, resp_out=42 at T+4 -> req_valid only at T+1, result_valid at T+5, result_data=42, IDLE after result_ready.
REQ-029 DIV accepted, kill at T+2, resp_valid at T+6 -> DRAIN T+3..T+6, no result_valid, IDLE at T+7, protocol_err=0.
REQ-030 kill coincident with resp_valid in WAIT -> no result_valid, IDLE next cycle; cmd_valid+kill in IDLE -> no req_valid.
REQ-031 result_ready held 0 for 10 cycles in DONE -> result_valid/result_data=42 stable; cmd_ready=0 throughout.
REQ-032 TIMEOUT_CYCLES=8, no response -> IDLE and protocol_err=1 eight cycles after entering WAIT; stray resp_valid in IDLE on a fresh reset -> protocol_err=1.
REQ-033 reset_n pulsed low in WAIT -> all outputs zero immediately, cmd_ready=1 after release.
